// File: rtl/ccg_response_compactor.sv
`default_nettype none
// ============================================================================
// Module      : ccg_response_compactor
// Description : Self-test response compactor. An LFSR drives stimulus vectors
//               into an external combinational block. Each response is folded
//               into a MISR. Runs are controlled by start/abort, and the final
//               signature and vector count are held until the next run.
// Revision    : 1.0 - initial release
// ============================================================================
module ccg_response_compactor #(
  parameter int X_W = 27,
  parameter int F_W = 22
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           abort,
  input  logic [15:0]    num_vectors,
  input  logic [X_W-1:0] seed,
  output logic [X_W-1:0] dut_x,
  input  logic [F_W-1:0] dut_f,
  output logic           busy,
  output logic           done,
  output logic [F_W-1:0] signature,
  output logic [15:0]    vec_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // An all-zero LFSR state would lock up, so it is replaced by this value.
  localparam logic [X_W-1:0] C_LFSR_INIT = {{(X_W-1){1'b0}}, 1'b1};

  state_t         r_state;
  logic [X_W-1:0] r_lfsr;
  logic [15:0]    r_num;

  logic [X_W-1:0] w_lfsr_next;
  logic [F_W-1:0] w_misr_next;
  logic [15:0]    w_count_next;
  logic           w_last;

  // Next LFSR state: Fibonacci shift-left for x^27+x^5+x^2+x+1.
  always_comb begin
    w_lfsr_next = {r_lfsr[X_W-2:0],
                   r_lfsr[X_W-1] ^ r_lfsr[4] ^ r_lfsr[1] ^ r_lfsr[0]};
  end

  // Next MISR state: internal-XOR register for x^22+x+1, response XORed in.
  always_comb begin
    w_misr_next    = '0;
    w_misr_next[0] = signature[F_W-1] ^ dut_f[0];
    w_misr_next[1] = signature[0] ^ signature[F_W-1] ^ dut_f[1];
    for (int i = 2; i < F_W; i++) begin
      w_misr_next[i] = signature[i-1] ^ dut_f[i];
    end
  end

  // Vector counter increment. This is the final vector when it matches the latched length.
  always_comb begin
    w_count_next = vec_count + 16'd1;
    w_last       = (w_count_next == r_num);
  end

  // Stimulus is driven only while running, otherwise held at zero.
  assign dut_x = (r_state == S_RUN) ? r_lfsr : '0;

  // Control FSM with registered busy/done.
  // It also updates the LFSR, MISR and counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_lfsr    <= C_LFSR_INIT;
      r_num     <= 16'd0;
      signature <= '0;
      vec_count <= 16'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          busy <= 1'b0;
          done <= 1'b0;
          // abort takes priority over a simultaneous start
          if (start && !abort) begin
            signature <= '0;
            vec_count <= 16'd0;
            if (num_vectors != 16'd0) begin
              r_num   <= num_vectors;
              r_lfsr  <= (seed == '0) ? C_LFSR_INIT : seed;
              r_state <= S_RUN;
              busy    <= 1'b1;
            end else begin
              r_state <= S_DONE;
              done    <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (abort) begin
            // partial signature and count are kept for inspection
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end else begin
            signature <= w_misr_next;
            r_lfsr    <= w_lfsr_next;
            vec_count <= w_count_next;
            if (w_last) begin
              r_state <= S_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ccg_response_compactor.sv
`default_nettype none
// ============================================================================
// Module      : tb_ccg_response_compactor
// Description : Scoreboard bench for ccg_response_compactor. A reference
//               model predicts the stimulus sequence and final signature.
//               A negedge monitor compares each presented vector and each
//               done pulse against queued expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ccg_response_compactor;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] num_vectors;
  logic [26:0] seed;
  logic [26:0] dut_x;
  logic [21:0] dut_f;
  logic        busy;
  logic        done;
  logic [21:0] signature;
  logic [15:0] vec_count;

  int mode;
  int n_cmp = 0;
  int n_bad = 0;

  logic [26:0] x_q[$];
  logic [37:0] exp_q[$];   // {signature, vec_count}

  ccg_response_compactor #(.X_W(27), .F_W(22)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .num_vectors(num_vectors), .seed(seed), .dut_x(dut_x), .dut_f(dut_f),
    .busy(busy), .done(done), .signature(signature), .vec_count(vec_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational block under test: constant patterns or a bit-mixing function.
  function automatic logic [21:0] bench_f(input logic [26:0] x, input int md);
    case (md)
      0:       return 22'h0;
      1:       return 22'h3FFFFF;
      default: return x[21:0] ^ {x[26:22], x[16:0]} ^ {x[10:0], x[26:16]};
    endcase
  endfunction

  assign dut_f = bench_f(dut_x, mode);

  // Polynomial view: feedback is the parity of the tapped bits.
  function automatic logic [26:0] ref_lfsr(input logic [26:0] s);
    return {s[25:0], ^(s & 27'h4000013)};
  endfunction

  // Polynomial view: multiply by x mod (x^22+x+1), then add the response.
  function automatic logic [21:0] ref_misr(input logic [21:0] m, input logic [21:0] f);
    return ({m[20:0], 1'b0} ^ (m[21] ? 22'h000003 : 22'h0)) ^ f;
  endfunction

  function automatic logic [21:0] ref_sig(input logic [26:0] sd, input int n, input int md);
    logic [26:0] s;
    logic [21:0] m;
    s = (sd == 27'h0) ? 27'h1 : sd;
    m = 22'h0;
    for (int i = 0; i < n; i++) begin
      m = ref_misr(m, bench_f(s, md));
      s = ref_lfsr(s);
    end
    return m;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Queue expectations and pulse start. Returns at posedge+1 after the start edge.
  task automatic start_run(input logic [26:0] sd, input int n, input int md,
                           input int n_x, input bit exp_done);
    logic [26:0] s;
    s = (sd == 27'h0) ? 27'h1 : sd;
    for (int i = 0; i < n_x; i++) begin
      x_q.push_back(s);
      s = ref_lfsr(s);
    end
    if (exp_done) exp_q.push_back({ref_sig(sd, n, md), 16'(n)});
    mode        = md;
    seed        = sd;
    num_vectors = 16'(n);
    start       = 1'b1;
    @(posedge clk); #1;
    start       = 1'b0;
  endtask

  // Count busy/done cycles until idle, then confirm the results hold.
  task automatic wait_idle(input int exp_busy, input logic [21:0] exp_sig,
                           input logic [15:0] exp_cnt);
    int nb = 0;
    int nd = 0;
    int c  = 0;
    while ((busy || done) && c < exp_busy + 20) begin
      if (busy) nb++;
      if (done) nd++;
      @(posedge clk); #1;
      c++;
    end
    chk("run_timeout", {63'h0, (busy || done)}, 64'h0);
    chk("busy_cycles", 64'(nb), 64'(exp_busy));
    chk("done_cycles", 64'(nd), 64'h1);
    repeat (2) begin @(posedge clk); #1; end
    chk("hold_signature", 64'(signature), 64'(exp_sig));
    chk("hold_vec_count", 64'(vec_count), 64'(exp_cnt));
  endtask

  task automatic wait_count(input logic [15:0] target);
    int c = 0;
    while (vec_count != target && c < 200) begin
      @(posedge clk); #1;
      c++;
    end
    chk("wait_count_timeout", 64'(vec_count), 64'(target));
  endtask

  // Monitor: compare every presented vector and every done pulse against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) begin
        if (x_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL dut_x_unexpected: got %0h expected no vector", dut_x);
        end else begin
          chk("dut_x", 64'(dut_x), 64'(x_q.pop_front()));
        end
      end else begin
        chk("dut_x_idle", 64'(dut_x), 64'h0);
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL done_unexpected: got done sig %0h cnt %0h expected none", signature, vec_count);
        end else begin
          logic [37:0] e;
          e = exp_q.pop_front();
          chk("done_signature", 64'(signature), 64'(e[37:16]));
          chk("done_vec_count", 64'(vec_count), 64'(e[15:0]));
        end
      end
    end
  end

  initial begin
    logic [26:0] sd;
    int          n;
    int          md;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    num_vectors = 16'h0; seed = 27'h0; mode = 0;
    #3;
    chk("reset_dut_x", 64'(dut_x), 64'h0);
    chk("reset_busy", {63'h0, busy}, 64'h0);
    chk("reset_done", {63'h0, done}, 64'h0);
    chk("reset_signature", 64'(signature), 64'h0);
    chk("reset_vec_count", 64'(vec_count), 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // seed 1, one vector, zero response
    start_run(27'h1, 1, 0, 1, 1);
    wait_idle(1, 22'h0, 16'd1);
    chk("single_vec_signature", 64'(signature), 64'h0);

    // seed 1, two vectors, all-ones response
    start_run(27'h1, 2, 1, 2, 1);
    @(posedge clk); #1;
    chk("sig_after_first", 64'(signature), 64'h3FFFFF);
    wait_idle(1, 22'h000002, 16'd2);
    chk("two_vec_signature", 64'(signature), 64'h000002);

    // zero seed is replaced by 1; three busy cycles
    start_run(27'h0, 3, 2, 3, 1);
    wait_idle(3, ref_sig(27'h0, 3, 2), 16'd3);

    // zero-length run goes straight to DONE
    start_run(27'h5A5A5A5, 0, 2, 0, 1);
    wait_idle(0, 22'h0, 16'd0);

    // randomized runs
    for (int k = 0; k < 10; k++) begin
      sd = 27'($urandom);
      if ($urandom_range(0, 4) == 0) sd = 27'h0;
      n  = $urandom_range(1, 40);
      md = $urandom_range(0, 2);
      start_run(sd, n, md, n, 1);
      wait_idle(n, ref_sig(sd, n, md), 16'(n));
    end

    // abort at vector 5 of 10: six vectors are presented, the sixth is not folded
    sd = 27'($urandom) | 27'h1;
    start_run(sd, 10, 2, 6, 0);
    wait_count(16'd5);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy", {63'h0, busy}, 64'h0);
    chk("abort_vec_count", 64'(vec_count), 64'd5);
    chk("abort_signature", 64'(signature), 64'(ref_sig(sd, 5, 2)));
    repeat (3) begin @(posedge clk); #1; end

    // abort beats start in IDLE
    abort = 1'b1; start = 1'b1; num_vectors = 16'd4; seed = 27'h123;
    @(posedge clk); #1;
    abort = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    chk("abort_start_busy", {63'h0, busy}, 64'h0);
    chk("abort_start_hold_cnt", 64'(vec_count), 64'd5);

    // mid-run start and input changes are ignored
    sd = 27'($urandom);
    start_run(sd, 10, 2, 10, 1);
    repeat (3) begin @(posedge clk); #1; end
    start = 1'b1; seed = 27'h7FFFFFF; num_vectors = 16'd3;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle(6, ref_sig(sd, 10, 2), 16'd10);

    // asynchronous reset mid-run, then a clean rerun
    sd = 27'($urandom);
    start_run(sd, 20, 2, 20, 1);
    wait_count(16'd7);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_dut_x", 64'(dut_x), 64'h0);
    chk("midrst_busy", {63'h0, busy}, 64'h0);
    chk("midrst_done", {63'h0, done}, 64'h0);
    chk("midrst_signature", 64'(signature), 64'h0);
    chk("midrst_vec_count", 64'(vec_count), 64'h0);
    x_q.delete();
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    start_run(sd, 20, 2, 20, 1);
    wait_idle(20, ref_sig(sd, 20, 2), 16'd20);

    repeat (3) begin @(posedge clk); #1; end
    chk("leftover_vectors", 64'(x_q.size()), 64'h0);
    chk("leftover_done", 64'(exp_q.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
